// File: rtl/bsg_manycore_mem_responder_pkg.sv
// Shared definitions for the manycore ready/valid-and memory responder.
//   - op_v2 request opcodes and return packet types
//   - packet width helpers (forward and return)
//   - mask width helper and the default mask width
//   - op_v2 -> return packet type mapping
//
// Forward packet layout, MSB to LSB:
//   {addr, op_v2, reg_id/store-mask, payload, src_y, src_x, y, x}
// Return packet layout, MSB to LSB:
//   {pkt_type, data, reg_id, y, x}
package bsg_manycore_mem_responder_pkg;

  localparam int op_width_lp       = 4;
  localparam int reg_id_width_lp   = 5;
  localparam int ret_type_width_lp = 2;

  typedef enum logic [3:0] {
    e_remote_load    = 4'd0,
    e_remote_store   = 4'd1,
    e_remote_sw      = 4'd2,
    e_cache_op       = 4'd3,
    e_remote_amoswap = 4'd4,
    e_remote_amoadd  = 4'd5,
    e_remote_amoxor  = 4'd6,
    e_remote_amoand  = 4'd7,
    e_remote_amoor   = 4'd8,
    e_remote_amomin  = 4'd9,
    e_remote_amomax  = 4'd10,
    e_remote_amominu = 4'd11,
    e_remote_amomaxu = 4'd12
  } bsg_manycore_packet_op_e;

  typedef enum logic [1:0] {
    e_return_credit   = 2'd0,
    e_return_int_wb   = 2'd1,
    e_return_float_wb = 2'd2,
    e_return_workload = 2'd3
  } bsg_manycore_return_packet_type_e;

  function automatic int mask_width(input int data_width);
    return data_width / 8;
  endfunction

  // Byte mask width for the default 32-bit data path.
  localparam int mask_width_lp = mask_width(32);

  function automatic int fwd_packet_width(input int addr_width, input int data_width,
                                          input int x_width, input int y_width);
    return addr_width + op_width_lp + reg_id_width_lp + data_width + 2 * (x_width + y_width);
  endfunction

  function automatic int ret_packet_width(input int data_width, input int x_width,
                                          input int y_width);
    return ret_type_width_lp + data_width + reg_id_width_lp + x_width + y_width;
  endfunction

  // Only loads write back a register; everything else returns a credit.
  function automatic bsg_manycore_return_packet_type_e ret_type(input logic [3:0] op);
    return (op == e_remote_load) ? e_return_int_wb : e_return_credit;
  endfunction

endpackage

// File: rtl/bsg_manycore_mem_responder_decode.sv
// Combinational request decoder.
//   fwd_data_i      forward request packet
//   sram_v_o        request touches the SRAM (supported opcode, address in range)
//   w_o             SRAM access is a write
//   mask_o          byte write mask
//   addr_o          SRAM word index
//   wdata_o         write payload
//   ret_type_o      return packet type
//   ret_reg_id_o    reg_id carried in the return packet
//   src_y_o/src_x_o return routing coordinates
//   err_o           unsupported opcode or out-of-range address
module bsg_manycore_mem_responder_decode
  import bsg_manycore_mem_responder_pkg::*;
  #(parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int lg_els_p       = 10,
    localparam int mask_width_lp = mask_width(data_width_p),
    localparam int fwd_width_lp  = fwd_packet_width(addr_width_p, data_width_p,
                                                    x_cord_width_p, y_cord_width_p))
  (input  logic [fwd_width_lp-1:0]    fwd_data_i,
   output logic                       sram_v_o,
   output logic                       w_o,
   output logic [mask_width_lp-1:0]   mask_o,
   output logic [lg_els_p-1:0]        addr_o,
   output logic [data_width_p-1:0]    wdata_o,
   output logic [1:0]                 ret_type_o,
   output logic [reg_id_width_lp-1:0] ret_reg_id_o,
   output logic [y_cord_width_p-1:0]  src_y_o,
   output logic [x_cord_width_p-1:0]  src_x_o,
   output logic                       err_o);

  localparam int src_x_lsb_lp   = x_cord_width_p + y_cord_width_p;
  localparam int src_y_lsb_lp   = src_x_lsb_lp + x_cord_width_p;
  localparam int payload_lsb_lp = src_y_lsb_lp + y_cord_width_p;
  localparam int reg_id_lsb_lp  = payload_lsb_lp + data_width_p;
  localparam int op_lsb_lp      = reg_id_lsb_lp + reg_id_width_lp;
  localparam int addr_lsb_lp    = op_lsb_lp + op_width_lp;

  logic [addr_width_p-1:0]    addr_full;
  logic [3:0]                 op;
  logic [reg_id_width_lp-1:0] reg_id;
  logic                       in_range;

  assign addr_full = fwd_data_i[addr_lsb_lp +: addr_width_p];
  assign op        = fwd_data_i[op_lsb_lp +: op_width_lp];
  assign reg_id    = fwd_data_i[reg_id_lsb_lp +: reg_id_width_lp];
  assign wdata_o   = fwd_data_i[payload_lsb_lp +: data_width_p];
  assign src_y_o   = fwd_data_i[src_y_lsb_lp +: y_cord_width_p];
  assign src_x_o   = fwd_data_i[src_x_lsb_lp +: x_cord_width_p];

  // Upper address bits must be zero: no aliasing onto the low words.
  assign in_range   = ((addr_full >> lg_els_p) == '0);
  assign addr_o     = addr_full[lg_els_p-1:0];
  assign ret_type_o = ret_type(op);

  always_comb begin
    sram_v_o     = 1'b0;
    w_o          = 1'b0;
    mask_o       = '0;
    ret_reg_id_o = reg_id;
    err_o        = 1'b0;
    case (op)
      e_remote_load: begin
        sram_v_o = in_range;
        err_o    = ~in_range;
      end
      e_remote_sw: begin
        sram_v_o = in_range;
        w_o      = 1'b1;
        mask_o   = '1;
        err_o    = ~in_range;
      end
      e_remote_store: begin
        // reg_id field carries the byte mask for masked stores.
        sram_v_o     = in_range;
        w_o          = 1'b1;
        mask_o       = reg_id[mask_width_lp-1:0];
        ret_reg_id_o = '0;
        err_o        = ~in_range;
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bsg_manycore_ready_and_mem_responder.sv
// Manycore memory responder on a ready/valid-and link.
//   clk_i, reset_i   clock, synchronous active-high reset
//   fwd_data_i/fwd_v_i/fwd_ready_and_o  request channel
//   rev_data_o/rev_v_o/rev_ready_and_i  return channel
//   error_o          sticky: unsupported opcode or out-of-range address
//
// Handshake: a transfer happens on a channel in any cycle where valid and
// ready are both high; valid does not depend on ready.
//
// Pipeline: S0 decodes and issues the SRAM access at accept, S1 forms the
// return packet from the 1-cycle read data, and a 2-entry FIFO drives rev_*.
// Occupancy (S1 + FIFO) is capped at 2 so S1 always has a free FIFO slot.
module bsg_manycore_ready_and_mem_responder
  import bsg_manycore_mem_responder_pkg::*;
  #(parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int els_p          = 1024,
    localparam int fwd_width_lp  = fwd_packet_width(addr_width_p, data_width_p,
                                                    x_cord_width_p, y_cord_width_p),
    localparam int ret_width_lp  = ret_packet_width(data_width_p, x_cord_width_p,
                                                    y_cord_width_p))
  (input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [fwd_width_lp-1:0] fwd_data_i,
   input  logic                    fwd_v_i,
   output logic                    fwd_ready_and_o,
   output logic [ret_width_lp-1:0] rev_data_o,
   output logic                    rev_v_o,
   input  logic                    rev_ready_and_i,
   output logic                    error_o);

  localparam int lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int mask_width_lp = mask_width(data_width_p);

  // decode
  logic                       dec_sram_v, dec_w, dec_err;
  logic [mask_width_lp-1:0]   dec_mask;
  logic [lg_els_lp-1:0]       dec_addr;
  logic [data_width_p-1:0]    dec_wdata;
  logic [1:0]                 dec_ret_type;
  logic [reg_id_width_lp-1:0] dec_reg_id;
  logic [y_cord_width_p-1:0]  dec_src_y;
  logic [x_cord_width_p-1:0]  dec_src_x;

  bsg_manycore_mem_responder_decode #(
    .addr_width_p  (addr_width_p),
    .data_width_p  (data_width_p),
    .x_cord_width_p(x_cord_width_p),
    .y_cord_width_p(y_cord_width_p),
    .lg_els_p      (lg_els_lp)
  ) decode (
    .fwd_data_i  (fwd_data_i),
    .sram_v_o    (dec_sram_v),
    .w_o         (dec_w),
    .mask_o      (dec_mask),
    .addr_o      (dec_addr),
    .wdata_o     (dec_wdata),
    .ret_type_o  (dec_ret_type),
    .ret_reg_id_o(dec_reg_id),
    .src_y_o     (dec_src_y),
    .src_x_o     (dec_src_x),
    .err_o       (dec_err)
  );

  // flow control
  logic       s1_v_q;
  logic [1:0] fifo_cnt_q, fifo_cnt_d;
  logic [1:0] occupancy;
  logic       rev_yumi, accept;

  assign rev_v_o   = (fifo_cnt_q != 2'd0);
  assign rev_yumi  = rev_v_o & rev_ready_and_i;
  assign occupancy = fifo_cnt_q + {1'b0, s1_v_q};
  // The rev handshake term lets a full pipeline keep streaming at 1/cycle.
  assign fwd_ready_and_o = ~reset_i & ((occupancy < 2'd2) | ((occupancy == 2'd2) & rev_yumi));
  assign accept = fwd_v_i & fwd_ready_and_o;

  // SRAM: write-first with registered read; write cycles leave rdata_q alone.
  logic [data_width_p-1:0] mem_q [els_p];
  logic [data_width_p-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (accept & dec_sram_v) begin
      if (dec_w) begin
        for (int b = 0; b < mask_width_lp; b++) begin
          if (dec_mask[b]) mem_q[dec_addr][b*8 +: 8] <= dec_wdata[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[dec_addr];
      end
    end
  end

  // S1 control
  logic                       s1_load_q;
  logic [1:0]                 s1_ret_type_q;
  logic [reg_id_width_lp-1:0] s1_reg_id_q;
  logic [y_cord_width_p-1:0]  s1_y_q;
  logic [x_cord_width_p-1:0]  s1_x_q;
  logic                       error_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_v_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      s1_v_q  <= accept;
      error_q <= error_q | (accept & dec_err);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_load_q     <= dec_sram_v & ~dec_w;
      s1_ret_type_q <= dec_ret_type;
      s1_reg_id_q   <= dec_reg_id;
      s1_y_q        <= dec_src_y;
      s1_x_q        <= dec_src_x;
    end
  end

  assign error_o = error_q;

  // Out-of-range loads and all non-loads return zero data.
  logic [data_width_p-1:0] s1_data;
  logic [ret_width_lp-1:0] s1_pkt;

  assign s1_data = s1_load_q ? rdata_q : '0;
  assign s1_pkt  = {s1_ret_type_q, s1_data, s1_reg_id_q, s1_y_q, s1_x_q};

  // 2-entry output FIFO; S1 pushes unconditionally thanks to the occupancy cap.
  logic [ret_width_lp-1:0] fifo_mem_q [2];
  logic                    fifo_wptr_q, fifo_rptr_q;

  assign fifo_cnt_d = fifo_cnt_q + {1'b0, s1_v_q} - {1'b0, rev_yumi};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifo_cnt_q  <= 2'd0;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (s1_v_q)   fifo_wptr_q <= ~fifo_wptr_q;
      if (rev_yumi) fifo_rptr_q <= ~fifo_rptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (s1_v_q) fifo_mem_q[fifo_wptr_q] <= s1_pkt;
  end

  assign rev_data_o = fifo_mem_q[fifo_rptr_q];

endmodule
